multi_port_fifo: RTL and testbench

Parametrised N-in/M-out synchronous FIFO with show-ahead read lanes, per-lane ready/valid handshakes, a synchronous flush and an almost-full watermark. It sits between fetch/decode and rename/dispatch as the superscalar instruction buffer, and is reusable for any multi-issue queue in the core. Multiple entries can be accepted and retired in the same cycle, and a branch-mispredict flush empties it in one cycle.

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/fifo_lane_count.sv | 27 ++
 rtl/multi_port_fifo.sv | 104 ++++++++++
 tb/tb_multi_port_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: lane-vector types, thermometer
// checks and the pointer/count width conventions derived from DEPTH.
package fifo_pkg;

  localparam int MAX_LANES = 4;

  typedef logic [MAX_LANES-1:0]           lane_vec_t;
  typedef logic [$clog2(MAX_LANES+1)-1:0] lane_cnt_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full queue is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // A thermometer vector has no 0 below a 1, so adding one carries cleanly
  // into the first zero and leaves no overlap with the original bits.
  function automatic logic is_therm(input lane_vec_t vec);
    return (vec & (vec + lane_vec_t'(1))) == '0;
  endfunction

  function automatic lane_cnt_t therm_cnt(input lane_vec_t vec);
    lane_cnt_t n;
    logic      run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      run = run & vec[i];
      if (run) n = n + lane_cnt_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_lane_count.sv
// Counts the contiguous low-order lanes where valid and ready both hold and
// flags any hole in either vector.
module fifo_lane_count
  import fifo_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0] i_valid,
  input  logic [LANES-1:0] i_ready,
  output lane_cnt_t        o_cnt,
  output logic             o_err
);

  lane_vec_t w_valid;
  lane_vec_t w_ready;

  always_comb begin
    w_valid              = '0;
    w_ready              = '0;
    w_valid[LANES-1:0]   = i_valid;
    w_ready[LANES-1:0]   = i_ready;
  end

  assign o_cnt = therm_cnt(w_valid & w_ready);
  assign o_err = !is_therm(w_valid) || !is_therm(w_ready);

endmodule

// File: rtl/multi_port_fifo.sv
// N-in/M-out show-ahead FIFO with per-lane ready/valid, one-cycle flush,
// almost-full watermark and a sticky lane-protocol error flag.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int PUSH_W   = 2,
  parameter int POP_W    = 2,
  parameter int AF_SLACK = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [PUSH_W-1:0]             push_valid,
  input  logic [PUSH_W-1:0][WIDTH-1:0]  push_data,
  output logic [PUSH_W-1:0]             push_ready,
  output logic [POP_W-1:0]              pop_valid,
  output logic [POP_W-1:0][WIDTH-1:0]   pop_data,
  input  logic [POP_W-1:0]              pop_ready,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          proto_err
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  cnt_t             r_count;
  logic             r_proto_err;

  lane_cnt_t         w_n_push;
  lane_cnt_t         w_n_pop;
  logic              w_push_err;
  logic              w_pop_err;
  logic [PUSH_W-1:0] w_wr_en;

  // Ready and valid come from the registered count only, so a write slot
  // can never be one that a same-cycle pop is still reading.
  for (genvar i = 0; i < PUSH_W; i++) begin : g_push
    assign push_ready[i] = r_count < cnt_t'(DEPTH - i);
    assign w_wr_en[i]    = !flush && (lane_cnt_t'(i) < w_n_push);
  end

  for (genvar i = 0; i < POP_W; i++) begin : g_pop
    assign pop_valid[i] = r_count > cnt_t'(i);
    assign pop_data[i]  = pop_valid[i] ? r_mem[r_rd_ptr + ptr_t'(i)] : '0;
  end

  fifo_lane_count #(.LANES(PUSH_W)) u_push_cnt (
    .i_valid (push_valid),
    .i_ready (push_ready),
    .o_cnt   (w_n_push),
    .o_err   (w_push_err)
  );

  fifo_lane_count #(.LANES(POP_W)) u_pop_cnt (
    .i_valid (pop_valid),
    .i_ready (pop_ready),
    .o_cnt   (w_n_pop),
    .o_err   (w_pop_err)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (w_wr_en[i]) r_mem[r_wr_ptr + ptr_t'(i)] <= push_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push_err || w_pop_err) r_proto_err <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(w_n_push);
        r_rd_ptr <= r_rd_ptr + ptr_t'(w_n_pop);
        r_count  <= r_count + cnt_t'(w_n_push) - cnt_t'(w_n_pop);
      end
    end
  end

  assign count       = r_count;
  assign full        = r_count == cnt_t'(DEPTH);
  assign empty       = r_count == '0;
  assign almost_full = r_count >= cnt_t'(DEPTH - AF_SLACK);
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_multi_port_fifo.sv
// Bench for multi_port_fifo: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_multi_port_fifo;

  localparam int WIDTH = 32, DEPTH = 16, PUSH_W = 2, POP_W = 2, AF_SLACK = 2;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        flush = 1'b0;
  logic [PUSH_W-1:0]           push_valid = '0;
  logic [PUSH_W-1:0][WIDTH-1:0] push_data = '0;
  logic [PUSH_W-1:0]           push_ready;
  logic [POP_W-1:0]            pop_valid;
  logic [POP_W-1:0][WIDTH-1:0] pop_data;
  logic [POP_W-1:0]            pop_ready = '0;
  logic [$clog2(DEPTH):0]      count;
  logic                        full, empty, almost_full, proto_err;

  multi_port_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .AF_SLACK(AF_SLACK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue of stored words plus the sticky error bit.
  logic [WIDTH-1:0] q[$];
  logic             m_proto = 1'b0;

  typedef struct {
    logic [1:0]  pv;
    logic [31:0] d0, d1;
    logic [1:0]  pr;
    logic        fl;
    int          cnt;
    logic [1:0]  pvld, prdy;
    logic [31:0] e0, e1;
    logic        full, empty, af;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] pv, logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] pr, logic fl, int cnt, logic [1:0] pvld,
                              logic [1:0] prdy, logic [31:0] e0, logic [31:0] e1,
                              logic f, logic e, logic af);
    vec_t v;
    v.pv = pv; v.d0 = d0; v.d1 = d1; v.pr = pr; v.fl = fl; v.cnt = cnt;
    v.pvld = pvld; v.prdy = prdy; v.e0 = e0; v.e1 = e1;
    v.full = f; v.empty = e; v.af = af;
    return v;
  endfunction

  function automatic int lead_ones(logic [1:0] v);
    return v[0] ? (v[1] ? 2 : 1) : 0;
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int sz, np, nq;
    if (!reset_n) begin
      q.delete();
      m_proto = 1'b0;
    end else begin
      sz = q.size();
      np = lead_ones(push_valid);
      nq = lead_ones(pop_ready);
      if (push_valid == 2'b10 || pop_ready == 2'b10) m_proto = 1'b1;
      if (np > DEPTH - sz) np = DEPTH - sz;
      if (nq > sz) nq = sz;
      if (flush) q.delete();
      else begin
        repeat (nq) void'(q.pop_front());
        for (int k = 0; k < np; k++) q.push_back(push_data[k]);
      end
    end
  endtask

  task automatic check_model(string tag);
    int sz;
    sz = q.size();
    cmp({tag, ".count"}, 64'(count), 64'(sz));
    cmp({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    cmp({tag, ".full"}, 64'(full), 64'(sz == DEPTH));
    cmp({tag, ".almost_full"}, 64'(almost_full), 64'(sz >= DEPTH - AF_SLACK));
    cmp({tag, ".proto_err"}, 64'(proto_err), 64'(m_proto));
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("%s.push_ready%0d", tag, i), 64'(push_ready[i]), 64'((DEPTH - sz) > i));
      cmp($sformatf("%s.pop_valid%0d", tag, i), 64'(pop_valid[i]), 64'(sz > i));
      cmp($sformatf("%s.pop_data%0d", tag, i), 64'(pop_data[i]), (sz > i) ? 64'(q[i]) : 64'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(logic [1:0] pv, logic [31:0] d0, logic [31:0] d1,
                       logic [1:0] pr, logic fl);
    push_valid   = pv;
    push_data[0] = d0;
    push_data[1] = d1;
    pop_ready    = pr;
    flush        = fl;
  endtask

  function automatic logic [1:0] therm2(int n);
    return (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
  endfunction

  initial begin
    // Directed table: basic flow, fill to full, push refused at full, count=15.
    tbl.push_back(mk(2'b11, 32'hA, 32'hB, 2'b00, 0, 2, 2'b11, 2'b11, 32'hA, 32'hB, 0, 0, 0));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 2'b11, 0, 0, 2'b00, 2'b11, 32'h0, 32'h0, 0, 1, 0));
    tbl.push_back(mk(2'b11, 32'hC, 32'hD, 2'b01, 0, 2, 2'b11, 2'b11, 32'hC, 32'hD, 0, 0, 0));
    tbl.push_back(mk(2'b11, 32'hE, 32'hF, 2'b01, 0, 3, 2'b11, 2'b11, 32'hD, 32'hE, 0, 0, 0));
    tbl.push_back(mk(2'b01, 32'h9, 32'h0, 2'b11, 0, 2, 2'b11, 2'b11, 32'hF, 32'h9, 0, 0, 0));
    for (int k = 0; k < 7; k++) begin
      int c;
      c = 4 + 2 * k;
      tbl.push_back(mk(2'b11, 32'h10 + 2 * k, 32'h11 + 2 * k, 2'b00, 0, c, 2'b11,
                       (c < 16) ? 2'b11 : 2'b00, 32'hF, 32'h9, c == 16, 0, c >= 14));
    end
    tbl.push_back(mk(2'b11, 32'h1E, 32'h1F, 2'b11, 0, 14, 2'b11, 2'b11, 32'h10, 32'h11, 0, 0, 1));
    tbl.push_back(mk(2'b11, 32'h20, 32'h21, 2'b00, 0, 16, 2'b11, 2'b00, 32'h10, 32'h11, 1, 0, 1));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 2'b01, 0, 15, 2'b11, 2'b01, 32'h11, 32'h12, 0, 0, 1));
    tbl.push_back(mk(2'b11, 32'h22, 32'h23, 2'b00, 0, 16, 2'b11, 2'b00, 32'h11, 32'h12, 1, 0, 1));
    tbl.push_back(mk(2'b11, 32'h30, 32'h31, 2'b11, 1, 0, 2'b00, 2'b11, 32'h0, 32'h0, 0, 1, 0));

    // Reset state, then release so the first table push lands on the next edge.
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pv, tbl[i].d0, tbl[i].d1, tbl[i].pr, tbl[i].fl);
      cycle();
      cmp($sformatf("row%0d.count", i), 64'(count), 64'(tbl[i].cnt));
      cmp($sformatf("row%0d.pop_valid", i), 64'(pop_valid), 64'(tbl[i].pvld));
      cmp($sformatf("row%0d.push_ready", i), 64'(push_ready), 64'(tbl[i].prdy));
      cmp($sformatf("row%0d.pop_data0", i), 64'(pop_data[0]), 64'(tbl[i].e0));
      cmp($sformatf("row%0d.pop_data1", i), 64'(pop_data[1]), 64'(tbl[i].e1));
      cmp($sformatf("row%0d.full", i), 64'(full), 64'(tbl[i].full));
      cmp($sformatf("row%0d.empty", i), 64'(empty), 64'(tbl[i].empty));
      cmp($sformatf("row%0d.almost_full", i), 64'(almost_full), 64'(tbl[i].af));
    end
    drive(2'b00, 0, 0, 2'b00, 0);
    cycle();
    check_model("post_table");

    // Flush at count 9 with a simultaneous two-lane push.
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h100 + 2 * k, 32'h101 + 2 * k, 2'b00, 0);
      cycle();
    end
    drive(2'b01, 32'h108, 32'h0, 2'b00, 0);
    cycle();
    cmp("flush.pre_count", 64'(count), 64'd9);
    drive(2'b11, 32'hDEAD0000, 32'hDEAD0001, 2'b11, 1);
    cycle();
    cmp("flush.count", 64'(count), 64'd0);
    cmp("flush.empty", 64'(empty), 64'd1);
    cmp("flush.pop_valid", 64'(pop_valid), 64'd0);
    cmp("flush.pop_data0", 64'(pop_data[0]), 64'd0);
    cmp("flush.pop_data1", 64'(pop_data[1]), 64'd0);
    drive(2'b00, 0, 0, 2'b00, 0);
    cycle();
    check_model("flush.idle");
    drive(2'b11, 32'h1, 32'h2, 2'b00, 0);
    cycle();
    cmp("flush.after_push0", 64'(pop_data[0]), 64'h1);
    cmp("flush.after_push1", 64'(pop_data[1]), 64'h2);

    // Randomized mix with push-heavy, pop-heavy and balanced phases (wraps pointers).
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 120; c++) begin
        int np, nq;
        np = (ph == 1) ? $urandom_range(0, 1) : $urandom_range(0, 2);
        nq = (ph == 0) ? $urandom_range(0, 1) : $urandom_range(0, 2);
        drive(therm2(np), $urandom, $urandom, therm2(nq), $urandom_range(0, 59) == 0);
        cycle();
        check_model($sformatf("rand%0d_%0d", ph, c));
      end
    end
    drive(2'b00, 0, 0, 2'b00, 1);
    cycle();

    // Lane holes: nothing is taken, error sticks through idle and flush.
    drive(2'b11, 32'h55, 32'h66, 2'b00, 0);
    cycle();
    drive(2'b10, 32'h77, 32'h88, 2'b10, 0);
    cycle();
    cmp("proto.set", 64'(proto_err), 64'd1);
    cmp("proto.count", 64'(count), 64'd2);
    cmp("proto.head", 64'(pop_data[0]), 64'h55);
    drive(2'b00, 0, 0, 2'b00, 0);
    repeat (3) begin
      cycle();
      check_model("proto.hold");
    end
    drive(2'b00, 0, 0, 2'b00, 1);
    cycle();
    cmp("proto.after_flush", 64'(proto_err), 64'd1);

    // Asynchronous reset between edges clears state without a clock.
    drive(2'b11, 32'h91, 32'h92, 2'b00, 0);
    cycle();
    cmp("areset.pre_count", 64'(count), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("areset.count", 64'(count), 64'd0);
    cmp("areset.proto_err", 64'(proto_err), 64'd0);
    cmp("areset.empty", 64'(empty), 64'd1);
    cmp("areset.push_ready", 64'(push_ready), 64'd3);
    cmp("areset.pop_valid", 64'(pop_valid), 64'd0);
    cmp("areset.pop_data0", 64'(pop_data[0]), 64'd0);
    q.delete();
    m_proto = 1'b0;
    drive(2'b00, 0, 0, 2'b00, 0);
    cycle();
    reset_n = 1'b1;
    drive(2'b11, 32'h5, 32'h6, 2'b00, 0);
    cycle();
    check_model("areset.first_push");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
